// File: rtl/adder_pipe.sv
// adder_pipe: add / subtract / accumulate unit with a STAGES-deep
// valid/ready pipeline. Arithmetic is evaluated as an operation enters
// stage 0; the later stages only carry {valid, c, carry, ovf} forward.
//
// A stage loads when it is empty or when its contents move on in the same
// cycle, so stalled results stay put and bubbles behind them get filled.
// The load enable of stage i works out to "out_ready, or some stage from
// i to the last is empty". That form depends only on registered valid bits,
// so in_ready never depends combinationally on in_valid.

module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             ovf
);

    localparam logic [1:0] MODE_ADD   = 2'b00;
    localparam logic [1:0] MODE_SUB   = 2'b01;
    localparam logic [1:0] MODE_ACC   = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0]            vld_nxt;
    logic [STAGES-1:0]            load;
    logic [STAGES-1:0][WIDTH-1:0] c_q;
    logic [STAGES-1:0][WIDTH-1:0] c_nxt;
    logic [STAGES-1:0]            carry_q;
    logic [STAGES-1:0]            carry_nxt;
    logic [STAGES-1:0]            ovf_q;
    logic [STAGES-1:0]            ovf_nxt;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_c;
    logic             res_carry;
    logic             res_ovf;
    logic             accept;

    // Operand selection and the single shared WIDTH+1 bit adder.
    // Subtract is a + ~b + 1, so carry doubles as "no borrow".
    always_comb begin
        op_x = a;
        op_y = b;
        cin  = 1'b0;
        case (mode)
            MODE_SUB: begin
                op_y = ~b;
                cin  = 1'b1;
            end
            MODE_ACC: begin
                op_x = acc;
                op_y = a;
            end
            default: ;
        endcase
        sum = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, cin};
        if (mode == MODE_CLEAR) begin
            res_c     = '0;
            res_carry = 1'b0;
            res_ovf   = 1'b0;
        end else begin
            res_c     = sum[WIDTH-1:0];
            res_carry = sum[WIDTH];
            res_ovf   = (op_x[WIDTH-1] == op_y[WIDTH-1]) &&
                        (sum[WIDTH-1] != op_x[WIDTH-1]);
        end
    end

    assign accept    = in_valid && in_ready;
    assign in_ready  = load[0];
    assign out_valid = vld[STAGES-1];
    assign c         = c_q[STAGES-1];
    assign carry     = carry_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        assign load[i] = out_ready | ~(&vld[STAGES-1:i]);

        if (i == 0) begin : g_first
            assign vld_nxt[i]   = load[i] ? in_valid : vld[i];
            assign c_nxt[i]     = (load[i] && in_valid) ? res_c     : c_q[i];
            assign carry_nxt[i] = (load[i] && in_valid) ? res_carry : carry_q[i];
            assign ovf_nxt[i]   = (load[i] && in_valid) ? res_ovf   : ovf_q[i];
        end else begin : g_next
            assign vld_nxt[i]   = load[i] ? vld[i-1] : vld[i];
            assign c_nxt[i]     = (load[i] && vld[i-1]) ? c_q[i-1]     : c_q[i];
            assign carry_nxt[i] = (load[i] && vld[i-1]) ? carry_q[i-1] : carry_q[i];
            assign ovf_nxt[i]   = (load[i] && vld[i-1]) ? ovf_q[i-1]   : ovf_q[i];
        end
    end

    // Pipeline registers and accumulator; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld     <= '0;
            c_q     <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            acc     <= '0;
        end else begin
            vld     <= vld_nxt;
            c_q     <= c_nxt;
            carry_q <= carry_nxt;
            ovf_q   <= ovf_nxt;
            if (accept && (mode == MODE_ACC)) begin
                acc <= res_c;
            end else if (accept && (mode == MODE_CLEAR)) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed table vectors, hand-written multi-cycle sequences
// (accumulate chaining, backpressure, reset mid-stream) and a randomized
// stream against an integer reference model.

module tb_adder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] c;
    logic       carry;
    logic       ovf;

    int total  = 0;
    int passed = 0;

    logic [7:0] acc_m;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       carry;
        logic       ovf;
    } vec_t;

    vec_t tbl [15];

    adder_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .carry     (carry),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model written with signed/unsigned integer arithmetic.
    function automatic logic [9:0] model(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
        int s;
        int sx;
        int sy;
        logic [7:0] r;
        logic cr;
        logic ov;
        r  = 8'd0;
        cr = 1'b0;
        ov = 1'b0;
        case (m)
            2'b00: begin
                s  = int'(x) + int'(y);
                r  = 8'(s);
                cr = (s > 255);
                sx = int'($signed(x));
                sy = int'($signed(y));
                ov = (sx + sy > 127) || (sx + sy < -128);
            end
            2'b01: begin
                s  = int'(x) - int'(y);
                r  = 8'(s);
                cr = (x >= y);
                sx = int'($signed(x));
                sy = int'($signed(y));
                ov = (sx - sy > 127) || (sx - sy < -128);
            end
            2'b10: begin
                s  = int'(acc_m) + int'(x);
                r  = 8'(s);
                cr = (s > 255);
                sx = int'($signed(acc_m));
                sy = int'($signed(x));
                ov = (sx + sy > 127) || (sx + sy < -128);
                acc_m = r;
            end
            default: begin
                acc_m = 8'd0;
            end
        endcase
        return {r, cr, ov};
    endfunction

    // One operation on an idle pipe: check acceptance, exact latency, result.
    task automatic apply_op(input string name, input logic [1:0] m, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] ec, input logic ecr,
                            input logic eov);
        mode      = m;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, 32'({c, carry, ovf}), 32'({ec, ecr, eov}));
        @(posedge clk); #1;
    endtask

    // Streaming run with a scoreboard. bp=1: fixed stream, out_ready low for
    // the first 4 cycles. bp=0: random in_valid/out_ready/mode/operands.
    task automatic run_stream(input int n, input bit bp);
        int sent = 0;
        int cyc  = 0;
        logic [9:0] q [$];
        logic acc_now;
        logic take_now;
        while ((sent < n || q.size() != 0) && cyc < 8 * n + 100) begin
            if (bp) begin
                in_valid  = (sent < n);
                out_ready = (cyc >= 4);
                mode      = 2'b00;
                a         = 8'(sent * 37 + 3);
                b         = 8'(sent * 11);
            end else begin
                in_valid  = (sent < n) && ($urandom_range(3) != 0);
                out_ready = ($urandom_range(3) != 0);
                mode      = 2'($urandom_range(3));
                a         = 8'($urandom);
                b         = 8'($urandom);
            end
            #1;
            if (bp && cyc == 3) begin
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_held_count", 32'(sent), 32'd2);
            end
            acc_now  = in_valid && in_ready;
            take_now = out_valid && out_ready;
            if (out_valid) begin
                if (q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
                else check(bp ? "bp_result" : "rand_result", 32'({c, carry, ovf}), 32'(q[0]));
                if (take_now && q.size() != 0) void'(q.pop_front());
            end
            if (acc_now) begin
                q.push_back(model(mode, a, b));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check(bp ? "bp_all_sent" : "rand_all_sent", 32'(sent), 32'(n));
        check(bp ? "bp_drained" : "rand_drained", 32'(q.size()), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    logic [1:0] ch_mode [5];
    logic [7:0] ch_a    [5];
    logic [7:0] ch_c    [5];

    initial begin
        tbl[0]  = '{2'b00, 8'd200, 8'd100, 8'd44,   1'b1, 1'b0};
        tbl[1]  = '{2'b00, 8'd100, 8'd100, 8'd200,  1'b0, 1'b1};
        tbl[2]  = '{2'b01, 8'd5,   8'd7,   8'd254,  1'b0, 1'b0};
        tbl[3]  = '{2'b01, 8'h80,  8'h01,  8'h7F,   1'b1, 1'b1};
        tbl[4]  = '{2'b00, 8'h00,  8'h00,  8'h00,   1'b0, 1'b0};
        tbl[5]  = '{2'b00, 8'hFF,  8'h01,  8'h00,   1'b1, 1'b0};
        tbl[6]  = '{2'b01, 8'd7,   8'd7,   8'd0,    1'b1, 1'b0};
        tbl[7]  = '{2'b00, 8'h7F,  8'h01,  8'h80,   1'b0, 1'b1};
        tbl[8]  = '{2'b01, 8'h00,  8'h80,  8'h80,   1'b0, 1'b1};
        tbl[9]  = '{2'b11, 8'h33,  8'h44,  8'h00,   1'b0, 1'b0};
        tbl[10] = '{2'b10, 8'h70,  8'h00,  8'h70,   1'b0, 1'b0};
        tbl[11] = '{2'b10, 8'h20,  8'h55,  8'h90,   1'b0, 1'b1};
        tbl[12] = '{2'b10, 8'h80,  8'h00,  8'h10,   1'b1, 1'b1};
        tbl[13] = '{2'b10, 8'h01,  8'hFF,  8'h11,   1'b0, 1'b0};
        tbl[14] = '{2'b11, 8'h05,  8'h05,  8'h00,   1'b0, 1'b0};

        ch_mode = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
        ch_a    = '{8'd10, 8'd20, 8'd30, 8'd0,  8'd5};
        ch_c    = '{8'd10, 8'd30, 8'd60, 8'd0,  8'd5};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        mode      = '0;
        acc_m     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'({c, carry, ovf}), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            apply_op($sformatf("vec%0d", i), tbl[i].mode, tbl[i].a, tbl[i].b,
                     tbl[i].c, tbl[i].carry, tbl[i].ovf);
        end

        // Back-to-back accumulate chain with a clear in the middle.
        out_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            if (j < 5) begin
                in_valid = 1'b1;
                mode     = ch_mode[j];
                a        = ch_a[j];
                b        = 8'hAA;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (j < 5) check($sformatf("chain_in_ready%0d", j), 32'(in_ready), 32'd1);
            if (j >= 2) begin
                check($sformatf("chain_valid%0d", j - 2), 32'(out_valid), 32'd1);
                check($sformatf("chain_c%0d", j - 2), 32'(c), 32'(ch_c[j - 2]));
            end
            @(posedge clk); #1;
        end
        check("chain_idle", 32'(out_valid), 32'd0);

        run_stream(8, 1'b1);

        // Reset in the middle of a stream.
        in_valid = 1'b1; mode = 2'b00; a = 8'd200; b = 8'd100;
        @(posedge clk); #1;
        mode = 2'b10; a = 8'd50;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'({c, carry, ovf}), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        apply_op("post_rst_acc", 2'b10, 8'd1, 8'd9, 8'd1, 1'b0, 1'b0);
        acc_m = 8'd1;

        run_stream(10000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
